// File: rtl/scale_win_ctrl_pkg.sv
// Shared geometry defaults, clamp limits and FSM encoding
// for the scaler window controller.
package scale_win_ctrl_pkg;

    localparam int DST_W  = 200;
    localparam int DST_H  = 150;
    localparam int DISP_W = 640;
    localparam int DISP_H = 480;

    localparam logic [10:0] X0_MAX = 11'(DISP_W - DST_W);
    localparam logic [10:0] Y0_MAX = 11'(DISP_H - DST_H);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_FILL,
        S_LOCKED
    } state_t;

    function automatic logic [10:0] clamp11(
        input logic [10:0] v,
        input logic [10:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/scale_win_ctrl_win_geom.sv
// Registered window hit, window offsets and border ring
// derived from the display counters and the active origin.
module win_geom #(
    parameter int DST_W  = 200,
    parameter int DST_H  = 150,
    parameter int DISP_W = 640,
    parameter int DISP_H = 480,
    parameter int BORDER = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de,
    input  logic        locked,
    input  logic [10:0] hcnt,
    input  logic [10:0] vcnt,
    input  logic [10:0] x0,
    input  logic [10:0] y0,
    output logic        win_active,
    output logic [7:0]  win_x,
    output logic [7:0]  win_y,
    output logic        border_active
);

    logic [11:0] h, v, xs, ys, xe, ye;
    logic        hit, ring;

    assign h  = {1'b0, hcnt};
    assign v  = {1'b0, vcnt};
    assign xs = {1'b0, x0};
    assign ys = {1'b0, y0};
    assign xe = xs + 12'(DST_W);
    assign ye = ys + 12'(DST_H);

    // Window and expanded ring tests, all in 12-bit space; ring clipped to display
    always_comb begin
        hit  = de & locked
             & (h >= xs) & (h < xe)
             & (v >= ys) & (v < ye);
        ring = (h + 12'(BORDER) >= xs)
             & (h < xe + 12'(BORDER))
             & (v + 12'(BORDER) >= ys)
             & (v < ye + 12'(BORDER))
             & (h < 12'(DISP_W))
             & (v < 12'(DISP_H));
    end

    // Register outputs; offsets forced to zero outside the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_active    <= 1'b0;
            win_x         <= '0;
            win_y         <= '0;
            border_active <= 1'b0;
        end else begin
            win_active    <= hit;
            win_x         <= hit ? 8'(h - xs) : 8'd0;
            win_y         <= hit ? 8'(v - ys) : 8'd0;
            border_active <= de & locked & ~hit & ring;
        end
    end

endmodule

// File: rtl/scale_win_ctrl.sv
// Scaler window controller: source-frame lock FSM, frame
// counting and vblank-synchronised window configuration.
module scale_win_ctrl #(
    parameter int DST_W  = scale_win_ctrl_pkg::DST_W,
    parameter int DST_H  = scale_win_ctrl_pkg::DST_H,
    parameter int DISP_W = scale_win_ctrl_pkg::DISP_W,
    parameter int DISP_H = scale_win_ctrl_pkg::DISP_H,
    parameter int BORDER = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        src_vsync,
    input  logic        disp_de,
    input  logic [10:0] disp_hcnt,
    input  logic [10:0] disp_vcnt,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic        cfg_en,
    input  logic [10:0] cfg_x0,
    input  logic [10:0] cfg_y0,
    output logic        frame_start,
    output logic        win_active,
    output logic [7:0]  win_x,
    output logic [7:0]  win_y,
    output logic        border_active,
    output logic        locked,
    output logic [15:0] frame_cnt
);

    import scale_win_ctrl_pkg::*;

    localparam logic [10:0] XLIM = 11'(DISP_W - DST_W);
    localparam logic [10:0] YLIM = 11'(DISP_H - DST_H);

    state_t      state, state_d;
    logic        vs_q, src_edge, fs_d;
    logic        pend_valid, pend_en, act_en;
    logic [10:0] pend_x, pend_y, act_x, act_y;
    logic        apply, en_eff;

    assign src_edge  = src_vsync & ~vs_q;
    assign cfg_ready = ~pend_valid;
    assign apply     = pend_valid
                     & (disp_vcnt == 11'(DISP_H))
                     & (disp_hcnt == 11'd0);
    // A disable landing at the apply point takes effect in that same cycle
    assign en_eff    = apply ? pend_en : act_en;

    // State, edge-detect history, frame pulse and frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            vs_q        <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_d;
            vs_q        <= src_vsync;
            frame_start <= fs_d;
            if (fs_d)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Next-state: disable overrides everything, else advance on source edges
    always_comb begin
        state_d = state;
        if (!en_eff) begin
            state_d = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:   state_d = S_ARM;
                S_ARM:    if (src_edge) state_d = S_FILL;
                S_FILL:   if (src_edge) state_d = S_LOCKED;
                S_LOCKED: state_d = S_LOCKED;
            endcase
        end
    end

    // Outputs: pulse request on qualifying edges, lock flag from state
    always_comb begin
        fs_d   = en_eff & src_edge & (state != S_IDLE);
        locked = (state == S_LOCKED);
    end

    // Config capture into pending regs, copy to active at the apply point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_en    <= 1'b0;
            pend_x     <= '0;
            pend_y     <= '0;
            act_en     <= 1'b0;
            act_x      <= '0;
            act_y      <= '0;
        end else if (cfg_valid && cfg_ready) begin
            pend_valid <= 1'b1;
            pend_en    <= cfg_en;
            pend_x     <= clamp11(cfg_x0, XLIM);
            pend_y     <= clamp11(cfg_y0, YLIM);
        end else if (apply) begin
            pend_valid <= 1'b0;
            act_en     <= pend_en;
            act_x      <= pend_x;
            act_y      <= pend_y;
        end
    end

    win_geom #(
        .DST_W  (DST_W),
        .DST_H  (DST_H),
        .DISP_W (DISP_W),
        .DISP_H (DISP_H),
        .BORDER (BORDER)
    ) u_geom (
        .clk           (clk),
        .rst_n         (rst_n),
        .de            (disp_de),
        .locked        (locked),
        .hcnt          (disp_hcnt),
        .vcnt          (disp_vcnt),
        .x0            (act_x),
        .y0            (act_y),
        .win_active    (win_active),
        .win_x         (win_x),
        .win_y         (win_y),
        .border_active (border_active)
    );

endmodule

// File: doc/scale_win_ctrl.md
SCALE_WIN_CTRL -- requirements
Module: scale_win_ctrl

Interface
REQ-001 Parameters (name, default, meaning): DST_W, 200, scaled image width; DST_H, 150, scaled image height; DISP_W, 640, display active width; DISP_H, 480, display active height; BORDER, 2, frame-border thickness in pixels.
REQ-002 clk  in  1  clock; every input is synchronous to clk.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 src_vsync  in  1  source vertical sync, active-high level.
REQ-005 disp_de  in  1  display active-video enable.
REQ-006 disp_hcnt, disp_vcnt  in  11 each  display pixel and line counters.
REQ-007 cfg_valid  in  1; cfg_ready  out  1  configuration handshake.
REQ-008 cfg_en  in  1; cfg_x0, cfg_y0  in  11 each  requested window enable and window origin.
REQ-009 frame_start  out  1  one-cycle bank-swap pulse to the scaler buffer.
REQ-010 win_active  out  1; win_x  out  8; win_y  out  8  read window to the scaler buffer.
REQ-011 border_active  out  1  display pixel lies in the border ring around the window.
REQ-012 locked  out  1; frame_cnt  out  16  scaler output valid; issued-frame counter.

Function
REQ-013 Source edge detect: src_vsync rising edge = src_vsync high and registered previous sample low.
REQ-014 FSM states are IDLE, ARM, FILL and LOCKED; the reset state is IDLE.
REQ-015 IDLE: frame_start is suppressed and locked = 0; the FSM moves to ARM when the active enable becomes 1.
REQ-016 ARM: on the first source edge the block pulses frame_start and moves to FILL.
REQ-017 FILL: on the next source edge the block pulses frame_start and moves to LOCKED.
REQ-018 LOCKED: the block pulses frame_start on every source edge, and locked = 1.
REQ-019 When the active enable goes to 0 in any state, the FSM moves to IDLE and locked clears on the next cycle.
REQ-020 If disable and a source edge coincide, the disable wins and no frame_start is issued.
REQ-021 frame_start is registered and asserts exactly 1 cycle after the qualifying edge cycle, for exactly 1 cycle.
REQ-022 frame_cnt increments by 1 per frame_start pulse and wraps from 0xFFFF to 0.
REQ-023 Config capture: cfg_ready = 1 when no update is pending; cfg_valid & cfg_ready captures cfg_en, cfg_x0 and cfg_y0 into pending registers; cfg_ready then drops to 0.
REQ-024 Capture clamp: cfg_x0 is clamped to DISP_W-DST_W (440) and cfg_y0 to DISP_H-DST_H (330).
REQ-025 Apply point: on the cycle with disp_vcnt == DISP_H and disp_hcnt == 0, the pending values copy to the active registers.
REQ-026 cfg_ready returns to 1 on the cycle after the apply point; the window therefore never changes within a visible frame.
REQ-027 Window hit: disp_de & locked & x0 <= disp_hcnt < x0+DST_W & y0 <= disp_vcnt < y0+DST_H, using active registers.
REQ-028 On a window hit, win_x = disp_hcnt - x0 and win_y = disp_vcnt - y0, truncated to 8 bits.
REQ-029 win_active, win_x and win_y are registered with latency 1 from the counters; win_x and win_y are 0 when not active.
REQ-030 border_active: disp_de & locked & not a window hit & the pixel lies inside the rectangle expanded by BORDER on every side; latency 1.
REQ-031 The border ring is clipped to the display area, and all window arithmetic uses 12 bits so no overflow occurs.

Reset
REQ-032 Reset values: FSM = IDLE; frame_start, win_active, border_active and locked = 0; win_x, win_y and frame_cnt = 0; cfg_ready = 1.
REQ-033 Reset values of the configuration: active and pending enable = 0, origins = 0, nothing pending; a mid-operation reset aborts any pending update.

Structure
REQ-034 The shared package holds DST_W, DST_H, DISP_W and DISP_H, the FSM state encoding, and the clamp limits.
REQ-035 A single sub-module, win_geom, computes the registered window hit, offsets and border ring from the counters and active origin.

Verification
REQ-036 Bench scenario 1: cfg (en=1, x0=220, y0=165), apply, then 3 source edges -> frame_start pulses on each, locked rises after the 2nd, frame_cnt = 3.
REQ-037 Bench scenario 2: locked, origin (220,165), hcnt = 220 and vcnt = 165 -> next cycle win_active = 1, win_x = 0, win_y = 0; hcnt = 419, vcnt = 314 -> win_x = 199, win_y = 149; hcnt = 420 -> win_active = 0.
REQ-038 Bench scenario 3: border at origin (220,165) -> border_active = 1 at (218,165) and (221,163), 0 at (217,165) and inside the window.
REQ-039 Bench scenario 4: cfg x0 = 600 and y0 = 400 mid-frame -> cfg_ready = 0 until the apply point, the window is unchanged before it, and the active origin becomes (440,330).
REQ-040 Bench scenario 5: cfg en=0 applied in the same cycle as a source edge -> no frame_start, locked = 0, FSM IDLE, window outputs 0.
REQ-041 Bench scenario 6: rst_n asserted while LOCKED with an update pending -> all outputs at reset values immediately, cfg_ready = 1, pending update discarded.
